// File: rtl/mem_copy_master_pkg.sv
// Shared Avalon-MM constants and the copy-engine state type.
package avmm_pkg;

  localparam int unsigned AVMM_ADDR_W  = 13;
  localparam int unsigned AVMM_DATA_W  = 32;
  localparam int unsigned ONCHIP_DEPTH = 7500;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FIN     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_master_if.sv
// Avalon-MM word-addressed bus between the copy master and the RAM slave port.
interface mem_copy_master_if
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_W = AVMM_ADDR_W,
  parameter int unsigned DATA_W = AVMM_DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/mem_copy_master_addr_gen.sv
// Loadable up/down source/destination address pair plus remaining-word counter.
module copy_addr_gen
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_W = AVMM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              descend,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_start,
  input  logic [ADDR_W-1:0] dst_start,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] next_src,
  output logic [ADDR_W-1:0] next_dst,
  output logic              last
);

  logic [ADDR_W-1:0] cur_src, cur_dst, remaining, next_rem;
  logic              desc_q, next_desc;

  // next_* are exported so the master can register the bus address in the same edge.
  always_comb begin
    next_src  = cur_src;
    next_dst  = cur_dst;
    next_rem  = remaining;
    next_desc = desc_q;
    if (load) begin
      next_src  = src_start;
      next_dst  = dst_start;
      next_rem  = len;
      next_desc = descend;
    end else if (step) begin
      next_src = desc_q ? cur_src - ADDR_W'(1) : cur_src + ADDR_W'(1);
      next_dst = desc_q ? cur_dst - ADDR_W'(1) : cur_dst + ADDR_W'(1);
      next_rem = remaining - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      desc_q    <= 1'b0;
    end else begin
      cur_src   <= next_src;
      cur_dst   <= next_dst;
      remaining <= next_rem;
      desc_q    <= next_desc;
    end
  end

  assign last = (remaining == ADDR_W'(1));

endmodule

// File: rtl/mem_copy_master.sv
// Avalon-MM master copying a block of words inside one RAM, overlap-safe by direction.
module mem_copy_master
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_W       = AVMM_ADDR_W,
  parameter int unsigned DATA_W       = AVMM_DATA_W,
  parameter int unsigned DEPTH        = ONCHIP_DEPTH,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_copy_master_if.master avm
);

  localparam int unsigned      LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(READ_LATENCY - 1);

  state_t              state, next_state;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                cs_q, cs_d, wr_q, wr_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                busy_d, done_d, err_d;

  logic [ADDR_W:0]     src_end, dst_end;
  logic                range_bad, descend, lat_done, load, read_accept, write_accept, last;
  logic [ADDR_W-1:0]   src_first, dst_first, next_src, next_dst;

  assign src_end      = {1'b0, src_addr} + {1'b0, len};
  assign dst_end      = {1'b0, dst_addr} + {1'b0, len};
  assign range_bad    = (src_end > DEPTH_X) || (dst_end > DEPTH_X);
  assign descend      = dst_addr > src_addr;
  assign src_first    = descend ? src_addr + len - ADDR_W'(1) : src_addr;
  assign dst_first    = descend ? dst_addr + len - ADDR_W'(1) : dst_addr;
  assign lat_done     = (lat_cnt == LAT_END);
  assign load         = (state == IDLE) && start;
  assign read_accept  = (state == RD_REQ) && !avm.waitrequest;
  assign write_accept = (state == WR_REQ) && !avm.waitrequest;

  copy_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .descend   (descend),
    .step      (write_accept),
    .src_start (src_first),
    .dst_start (dst_first),
    .len       (len),
    .next_src  (next_src),
    .next_dst  (next_dst),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      data_q    <= '0;
      address_q <= '0;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      lat_cnt   <= lat_cnt_d;
      data_q    <= data_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      wr_q      <= wr_d;
      be_q      <= be_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (range_bad || len == '0) ? FIN : RD_REQ;
      RD_REQ:  if (read_accept) next_state = RD_WAIT;
      RD_WAIT: if (lat_done) next_state = WR_REQ;
      WR_REQ:  if (write_accept) next_state = last ? FIN : RD_REQ;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so every bus/status pin comes straight from a flop.
  always_comb begin
    cs_d      = (next_state == RD_REQ) || (next_state == WR_REQ);
    wr_d      = (next_state == WR_REQ);
    be_d      = wr_d ? '1 : '0;
    busy_d    = (next_state != IDLE);
    done_d    = (next_state == FIN);
    err_d     = (state == IDLE) && (next_state == FIN) && range_bad;
    address_d = address_q;
    if (next_state == RD_REQ)      address_d = next_src;
    else if (next_state == WR_REQ) address_d = next_dst;
    lat_cnt_d = (state == RD_WAIT) ? lat_cnt + LAT_W'(1) : '0;
    data_d    = (state == RD_WAIT && lat_done) ? avm.readdata : data_q;
  end

  assign avm.address    = address_q;
  assign avm.chipselect = cs_q;
  assign avm.write      = wr_q;
  assign avm.byteenable = be_q;
  assign avm.writedata  = data_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed + randomized bench for mem_copy_master with an on-chip RAM model and memmove reference.
module tb_mem_copy_master;
  import avmm_pkg::*;

  localparam int unsigned AW    = AVMM_ADDR_W;
  localparam int unsigned DW    = AVMM_DATA_W;
  localparam int unsigned DEPTH = ONCHIP_DEPTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] len = '0;
  logic          busy, done, err;

  mem_copy_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm();

  mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .avm      (avm)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] rd_q;
  logic [AW-1:0] rd_log  [0:1023];
  logic          load_req = 1'b0;
  logic          stall_en = 1'b0;
  int unsigned   cs_cycles = 0;
  int unsigned   rd_cnt = 0;
  int unsigned   stall_viol = 0;
  int unsigned   checks = 0;
  int unsigned   errors = 0;

  // RAM model: registered read data, one cycle after the accepted read.
  assign avm.readdata = rd_q;
  always @(posedge clk) begin
    if (load_req) mem <= ref_mem;
    else if (avm.chipselect && !avm.waitrequest) begin
      if (avm.write) begin
        if (avm.address < AW'(DEPTH)) mem[avm.address] <= avm.writedata;
      end else begin
        rd_q <= (avm.address < AW'(DEPTH)) ? mem[avm.address] : 'x;
        rd_log[rd_cnt[9:0]] <= avm.address;
        rd_cnt <= rd_cnt + 1;
      end
    end
    if (avm.chipselect) cs_cycles <= cs_cycles + 1;
  end

  always @(posedge clk) begin
    #2;
    avm.waitrequest = stall_en && ($urandom_range(0, 99) < 30);
  end

  logic          p_cs = 1'b0, p_wr = 1'b0, p_stall = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wd = '0;
  always @(negedge clk) begin
    if (reset_n && p_cs && p_stall &&
        (avm.chipselect !== p_cs || avm.write !== p_wr ||
         avm.address !== p_addr || avm.writedata !== p_wd))
      stall_viol = stall_viol + 1;
    p_cs    = avm.chipselect;
    p_wr    = avm.write;
    p_addr  = avm.address;
    p_wd    = avm.writedata;
    p_stall = avm.waitrequest;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_mem();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic ref_copy(input int unsigned s, input int unsigned d, input int unsigned l);
    logic [DW-1:0] tmp[$];
    for (int unsigned i = 0; i < l; i++) tmp.push_back(ref_mem[s+i]);
    for (int unsigned i = 0; i < l; i++) ref_mem[d+i] = tmp[i];
  endtask

  task automatic compare_mem(input string tag);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) begin bad = i; break; end
    check($sformatf("%s.mem[%0d]", tag, bad), 64'(mem[bad]), 64'(ref_mem[bad]));
  endtask

  function automatic logic [53:0] out_vec();
    return {busy, done, err, avm.chipselect, avm.write, avm.byteenable, avm.address, avm.writedata};
  endfunction

  task automatic run_copy(input string tag, input int unsigned s, input int unsigned d,
                          input int unsigned l, input logic exp_err, input int exp_cyc);
    int unsigned cs0, n, budget;
    bit seen;
    cs0    = cs_cycles;
    budget = 30 * l + 20;
    seen   = 0;
    @(negedge clk);
    src_addr = AW'(s); dst_addr = AW'(d); len = AW'(l); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, ".busy"}, busy, 1);
    while (n < budget) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
      n++;
    end
    check({tag, ".done_seen"}, seen, 1);
    if (exp_cyc >= 0) check({tag, ".done_cycle"}, n, exp_cyc);
    check({tag, ".err"}, err, exp_err);
    @(negedge clk);
    check({tag, ".after_done"}, {done, busy, err}, 0);
    if (exp_err || l == 0) check({tag, ".no_bus"}, cs_cycles - cs0, 0);
    if (!exp_err) begin
      ref_copy(s, d, l);
      compare_mem(tag);
    end
  endtask

  initial begin
    int unsigned s, d, l, rb, n;
    for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    sync_mem();
    repeat (2) @(negedge clk);
    check("reset.outputs", out_vec(), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle.outputs", out_vec(), 0);

    for (int unsigned i = 0; i < 16; i++) ref_mem[i] = 32'hA000_0000 + i;
    sync_mem();
    run_copy("t1", 0, 100, 16, 1'b0, 49);
    check("t1.word115", mem[115], 32'hA000_000F);

    for (int unsigned i = 0; i < 4; i++) ref_mem[10+i] = i + 1;
    sync_mem();
    rb = rd_cnt;
    run_copy("t2", 10, 12, 4, 1'b0, 13);
    for (int unsigned k = 0; k < 4; k++)
      check($sformatf("t2.rd_addr%0d", k), rd_log[(rb+k) % 1024], 13 - k);
    check("t2.word15", mem[15], 4);

    run_copy("t3.src_range", 7490, 0, 20, 1'b1, 1);
    run_copy("t3.dst_range", 0, 7481, 20, 1'b1, 1);
    run_copy("t3.edge_ok", 7480, 7000, 20, 1'b0, 61);
    run_copy("t4.len0", 5, 9, 0, 1'b0, 1);
    run_copy("same", 300, 300, 5, 1'b0, 16);

    for (int unsigned r = 0; r < 4; r++) begin
      l = $urandom_range(1, 40);
      s = $urandom_range(0, DEPTH - l);
      d = (r == 1) ? s + $urandom_range(1, l) : $urandom_range(0, DEPTH - l);
      if (d > DEPTH - l) d = DEPTH - l;
      run_copy($sformatf("rand%0d", r), s, d, l, 1'b0, 3 * l + 1);
    end

    stall_en = 1'b1;
    run_copy("t5.stall", 1000, 1020, 64, 1'b0, -1);
    stall_en = 1'b0;
    check("t5.stall_stable", stall_viol, 0);

    // start pulse while busy must not re-latch parameters
    @(negedge clk);
    src_addr = AW'(2000); dst_addr = AW'(2100); len = AW'(8); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 5) begin src_addr = AW'(3000); dst_addr = AW'(3100); len = AW'(30); start = 1'b1; end
      if (n == 6) start = 1'b0;
    end
    check("t6.busy_pulse_cycle", n, 25);
    check("t6.busy_pulse_err", err, 0);
    ref_copy(2000, 2100, 8);
    @(negedge clk);
    compare_mem("t6.busy_pulse");

    @(negedge clk);
    src_addr = AW'(4000); dst_addr = AW'(4100); len = AW'(40); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("t6.midcopy_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6.midcopy_reset", out_vec(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6.midcopy_idle", {busy, done, avm.chipselect}, 0);

    @(negedge clk);
    src_addr = AW'(500); dst_addr = AW'(600); len = AW'(20); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    src_addr = AW'(700); len = AW'(5); start = 1'b1; reset_n = 1'b0;
    #1;
    check("t6.pulse_reset", out_vec(), 0);
    @(negedge clk);
    start = 1'b0; reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6.pulse_idle", {busy, done, avm.chipselect}, 0);

    sync_mem();
    run_copy("t6.after", 50, 60, 3, 1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
